// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential 2W/W restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Bits needed to hold a step count of value-1 down to 0.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, q} left, trial-subtract divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             no_borrow_s;

  // Top bit of trial_s is the borrow; shifted rem stays below 2*divisor.
  assign shifted_s   = {rem, q[WIDTH-1]};
  assign trial_s     = shifted_s - {2'b00, divisor};
  assign no_borrow_s = ~trial_s[WIDTH+1];
  assign rem_next    = no_borrow_s ? trial_s[WIDTH:0] : shifted_s[WIDTH:0];
  assign q_next      = {q[WIDTH-2:0], no_borrow_s};

endmodule

// File: rtl/seq_divider64by32.sv
// Multicycle 2W-by-W unsigned restoring divider with valid/ready on both sides.
module seq_divider64by32
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_r, next_state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH:0]   rem_r, rem_next_s;
  logic [WIDTH-1:0] q_r, q_next_s;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quotient_r, remainder_r;
  logic             dbz_r, ovf_r;
  logic             div_zero_s, ovf_s;

  assign div_zero_s = (divisor == {WIDTH{1'b0}});
  assign ovf_s      = (dividend[2*WIDTH-1:WIDTH] >= divisor);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (divisor_r),
    .rem_next (rem_next_s),
    .q_next   (q_next_s)
  );

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (div_zero_s || ovf_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = BUSY;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == {CW{1'b0}}) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath and result registers; results change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      q_r         <= {WIDTH{1'b0}};
      divisor_r   <= {WIDTH{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            divisor_r <= divisor;
            rem_r     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_r       <= dividend[WIDTH-1:0];
            cnt_r     <= CNT_LAST;
            if (div_zero_s) begin
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= dividend[WIDTH-1:0];
              dbz_r       <= 1'b1;
              ovf_r       <= 1'b0;
            end else if (ovf_s) begin
              quotient_r  <= {WIDTH{1'b1}};
              remainder_r <= {WIDTH{1'b0}};
              dbz_r       <= 1'b0;
              ovf_r       <= 1'b1;
            end
          end
        end
        BUSY: begin
          rem_r <= rem_next_s;
          q_r   <= q_next_s;
          if (cnt_r == {CW{1'b0}}) begin
            quotient_r  <= q_next_s;
            remainder_r <= rem_next_s[WIDTH-1:0];
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
          end else begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign out_valid   = (state_r == DONE);
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_seq_divider64by32.sv
// Directed and random round-trip bench for seq_divider64by32 with a result scoreboard.
module tb_seq_divider64by32;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_divider64by32 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: plain 64-bit arithmetic plus the special cases.
  function automatic exp_t model(input logic [63:0] n, input logic [31:0] d);
    exp_t e;
    logic [63:0] q64;
    logic [63:0] r64;
    if (d == 32'd0) begin
      e = '{q: 32'hFFFF_FFFF, r: n[31:0], dbz: 1'b1, ovf: 1'b0};
    end else if (n[63:32] >= d) begin
      e = '{q: 32'hFFFF_FFFF, r: 32'd0, dbz: 1'b0, ovf: 1'b1};
    end else begin
      q64 = n / {32'd0, d};
      r64 = n % {32'd0, d};
      e = '{q: q64[31:0], r: r64[31:0], dbz: 1'b0, ovf: 1'b0};
    end
    return e;
  endfunction

  // Drive one request until accepted; optionally record its expected result.
  task automatic send(input logic [63:0] n, input logic [31:0] d, input bit push, input exp_t e);
    int guard;
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("accept_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    if (push) sb.push_back(e);
  endtask

  // Wait for out_valid, returning the number of cycles after the accept edge.
  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      tick();
      cycles++;
    end
    if (!out_valid) check("result_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic compare_and_accept(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_q"},   {32'd0, quotient},  {32'd0, e.q});
    check({tag, "_r"},   {32'd0, remainder}, {32'd0, e.r});
    check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
    check({tag, "_ovf"}, {63'd0, overflow},    {63'd0, e.ovf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int   cycles;
    int   stray;
    exp_t e;
    logic [31:0] a;
    logic [31:0] b;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 64'd0;
    divisor   = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_q",   {32'd0, quotient},  64'd0);
    check("rst_r",   {32'd0, remainder}, 64'd0);
    check("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);

    // 100 / 7
    send(64'd100, 32'd7, 1'b1, '{q: 32'd14, r: 32'd2, dbz: 1'b0, ovf: 1'b0});
    check("small_busy_in_ready", {63'd0, in_ready}, 64'd0);
    wait_result(cycles);
    check("small_latency", cycles, 64'd32);
    compare_and_accept("small");

    // Maximum product
    send(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 1'b1,
         '{q: 32'hFFFF_FFFF, r: 32'd0, dbz: 1'b0, ovf: 1'b0});
    wait_result(cycles);
    compare_and_accept("maxprod");

    // Divide by zero
    send(64'h0000_0000_1234_5678, 32'd0, 1'b1,
         '{q: 32'hFFFF_FFFF, r: 32'h1234_5678, dbz: 1'b1, ovf: 1'b0});
    wait_result(cycles);
    check("dbz_latency", cycles, 64'd0);
    compare_and_accept("dbz");

    // Overflow, smallest case
    send(64'h0000_0001_0000_0000, 32'd1, 1'b1,
         '{q: 32'hFFFF_FFFF, r: 32'd0, dbz: 1'b0, ovf: 1'b1});
    wait_result(cycles);
    check("ovf_latency", cycles, 64'd0);
    compare_and_accept("ovf");

    // Just below overflow: hi word one less than divisor
    e = model(64'h0000_0004_FFFF_FFFF, 32'd5);
    send(64'h0000_0004_FFFF_FFFF, 32'd5, 1'b1, e);
    wait_result(cycles);
    compare_and_accept("edge_hi");

    // Backpressure: result must hold for 10 cycles
    send(64'd1_000_003, 32'd1000, 1'b1, '{q: 32'd1000, r: 32'd3, dbz: 1'b0, ovf: 1'b0});
    wait_result(cycles);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_q", {32'd0, quotient}, 64'd1000);
      check("bp_hold_r", {32'd0, remainder}, 64'd3);
      check("bp_hold_hs", {62'd0, out_valid, in_ready}, 64'd2);
    end
    compare_and_accept("bp");

    // Reset during BUSY aborts the request
    send(64'd100, 32'd7, 1'b0, e);
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  {63'd0, in_ready},  64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_q", {32'd0, quotient}, 64'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) stray++;
    end
    check("abort_no_result", stray, 64'd0);
    send(64'd100, 32'd7, 1'b1, '{q: 32'd14, r: 32'd2, dbz: 1'b0, ovf: 1'b0});
    wait_result(cycles);
    check("post_abort_latency", cycles, 64'd32);
    compare_and_accept("post_abort");

    // Random round trip: (A*B)/B == A, remainder 0
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      send({32'd0, a} * {32'd0, b}, b, 1'b1, '{q: a, r: 32'd0, dbz: 1'b0, ovf: 1'b0});
      wait_result(cycles);
      compare_and_accept("rt");
    end

    check("sb_drained", sb.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
